mplex_demux: RTL

Receive-side counterpart of the dice/traffic-light multiplexer: takes the shared 3-bit `result` bus plus its `sel` line and splits it back into a dice channel and a traffic-light channel. Each channel is registered, checked for legality, and held. The traffic channel runs a sequence-checking FSM, and protocol violations are flagged and counted. It sits at the consumer end of the multiplexed bus, typically on the display or checker side.

---
 rtl/mplex_pkg.sv | 41 ++++
 rtl/mplex_demux_tl_checker.sv | 44 ++++
 rtl/mplex_demux.sv | 86 ++++++++
 3 files changed

// File: rtl/mplex_pkg.sv
// rtl/mplex_pkg.sv - shared traffic-light encodings and dice limits for mplex_demux
package mplex_pkg;

  typedef enum logic [2:0] {
    TL_UNSYNC,
    TL_RED,
    TL_RED_AMBER,
    TL_GREEN,
    TL_AMBER
  } tl_state_t;

  localparam logic [2:0] PAT_RED   = 3'b100;
  localparam logic [2:0] PAT_RA    = 3'b110;
  localparam logic [2:0] PAT_GREEN = 3'b001;
  localparam logic [2:0] PAT_AMBER = 3'b010;

  localparam logic [2:0] DICE_MIN = 3'd1;
  localparam logic [2:0] DICE_MAX = 3'd6;

  // Illegal light patterns map to TL_UNSYNC.
  function automatic tl_state_t pat_state(input logic [2:0] pat);
    case (pat)
      PAT_RED:   return TL_RED;
      PAT_RA:    return TL_RED_AMBER;
      PAT_GREEN: return TL_GREEN;
      PAT_AMBER: return TL_AMBER;
      default:   return TL_UNSYNC;
    endcase
  endfunction

  function automatic tl_state_t next_state(input tl_state_t s);
    case (s)
      TL_RED:       return TL_RED_AMBER;
      TL_RED_AMBER: return TL_GREEN;
      TL_GREEN:     return TL_AMBER;
      TL_AMBER:     return TL_RED;
      default:      return TL_UNSYNC;
    endcase
  endfunction

endpackage

// File: rtl/mplex_demux_tl_checker.sv
// rtl/mplex_demux_tl_checker.sv - traffic-light sequence FSM with legal-transition check
module tl_checker
  import mplex_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       force_unsync,
  input  logic [2:0] pat,
  output logic [2:0] lights,
  output logic       locked,
  output logic       err
);

  tl_state_t state;
  tl_state_t p_st;

  assign p_st   = pat_state(pat);
  assign locked = (state != TL_UNSYNC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= TL_UNSYNC;
      lights <= '0;
      err    <= 1'b0;
    end else begin
      err <= 1'b0;
      if (force_unsync) begin
        state <= TL_UNSYNC;
      end else if (en) begin
        // From UNSYNC any legal pattern locks; when locked only hold or advance.
        if (p_st != TL_UNSYNC &&
            (state == TL_UNSYNC || p_st == state || p_st == next_state(state))) begin
          state  <= p_st;
          lights <= pat;
        end else begin
          state <= TL_UNSYNC;
          err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mplex_demux.sv
// rtl/mplex_demux.sv - splits the shared dice/traffic bus; MPLEX_DEMUX_ERRCNT_EN adds the error counter
module mplex_demux
  import mplex_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [2:0]       result,
  output logic [2:0]       dice_val,
  output logic             dice_valid,
  output logic             red,
  output logic             amber,
  output logic             green,
  output logic             tl_locked,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);

  logic       sel_q, sel_qq, res_vld, dice_first, dice_err, tl_err;
  logic [2:0] res_q, lights;
  logic       accept, dice_ok;

  // res_vld keeps the reset contents of res_q from being decoded as a sample.
  assign accept  = res_vld && (sel_q == sel_qq);
  assign dice_ok = (res_q >= DICE_MIN) && (res_q <= DICE_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q      <= 1'b0;
      sel_qq     <= 1'b0;
      res_q      <= '0;
      res_vld    <= 1'b0;
      dice_val   <= '0;
      dice_valid <= 1'b0;
      dice_err   <= 1'b0;
      dice_first <= 1'b1;
    end else begin
      sel_q      <= sel;
      sel_qq     <= sel_q;
      res_q      <= result;
      res_vld    <= 1'b1;
      dice_valid <= 1'b0;
      dice_err   <= 1'b0;
      if (!sel_q && sel_qq) begin
        dice_first <= 1'b1;
      end else if (accept && !sel_q) begin
        if (dice_ok) begin
          dice_val   <= res_q;
          dice_valid <= (res_q != dice_val) || dice_first;
          dice_first <= 1'b0;
        end else begin
          dice_err <= 1'b1;
        end
      end
    end
  end

  tl_checker u_tl (
    .clk          (clk),
    .rst          (rst),
    .en           (accept && sel_q),
    .force_unsync (sel_q && !sel_qq),
    .pat          (res_q),
    .lights       (lights),
    .locked       (tl_locked),
    .err          (tl_err)
  );

  assign {red, amber, green} = lights;
  assign seq_err             = dice_err | tl_err;

`ifdef MPLEX_DEMUX_ERRCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count <= '0;
    end else if (seq_err && (err_count != '1)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end
`else
  assign err_count = '0;
`endif

endmodule
